dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between the CPU data path (execute-stage load/store) and a DMA port used by the UART program loader.
- Grants one requester per cycle and routes its address, write data and byte mask to the memory.
- Tags each read so that read data returns to the requester that issued it, one cycle later.
- Raises a stall to the pipeline controller when the CPU is refused; a starvation counter guarantees DMA progress.

Parameters:
- AW, 14, memory word-address width.
- STARVE_MAX, 4, consecutive contended cycles DMA may be refused before it is forced a grant (legal range 1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- cpu_req  input  1  CPU access request
- cpu_we  input  4  CPU byte write mask; 0 means read
- cpu_addr  input  AW  CPU word address
- cpu_wdata  input  32  CPU write data
- cpu_gnt  output  1  CPU access accepted this cycle
- cpu_stall  output  1  equals cpu_req & ~cpu_gnt; drives the pipeline stall
- cpu_rvalid  output  1  CPU read data valid
- cpu_rdata  output  32  CPU read data
- dma_req  input  1  DMA access request
- dma_we  input  4  DMA byte write mask; 0 means read
- dma_addr  input  AW  DMA word address
- dma_wdata  input  32  DMA write data
- dma_gnt  output  1  DMA access accepted this cycle
- dma_rvalid  output  1  DMA read data valid
- dma_rdata  output  32  DMA read data
- mem_en  output  1  memory enable
- mem_we  output  4  memory byte write enables
- mem_addr  output  AW  memory address
- mem_din  output  32  memory write data
- mem_dout  input  32  memory read data, valid one cycle after mem_en with mem_we==0

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-low; all state updates on the clk rising edge.
- Reset values while rst==0: cpu_gnt=0, dma_gnt=0, cpu_stall=0, mem_en=0, mem_we=0, cpu_rvalid=0, dma_rvalid=0, starve_cnt=0, rd_owner=NONE.
- Grants are combinational from the requests and the registered starve_cnt:
  - Only one port requesting: that port is granted.
  - Both requesting: CPU wins unless starve_cnt==STARVE_MAX, in which case DMA wins.
  - At most one grant is ever high.
- Memory drive:
  - mem_en = cpu_gnt | dma_gnt.
  - mem_we, mem_addr and mem_din are taken from the granted port.
  - With no grant, mem_we=0 and address/data hold their previous value.
- Requester rules:
  - A port keeps req high with stable payload until it sees gnt in the same cycle.
  - A write completes on its grant cycle.
- Read tagging:
  - rd_owner register takes the value CPU, DMA or NONE, set on any granted read and NONE otherwise.
  - Next cycle, the owning port's rvalid=1 and its rdata=mem_dout.
  - The non-owner's rvalid=0 and its rdata=0.
- Back-to-back reads from alternating ports each get a correct 1-cycle return; there is no bubble.
- starve_cnt (width ceil(log2(STARVE_MAX+1))):
  - Increments when dma_req & ~dma_gnt.
  - Clears when dma_gnt or when ~dma_req.
  - Saturates at STARVE_MAX and is cleared on the forced grant.
- Reset mid-read: if rst is low on the cycle after a granted read, both rvalids are 0 and the read is dropped.
- Stall: cpu_stall is combinational and asserts in the same cycle the CPU is refused.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - Adds output conflict_cnt[31:0], counting cycles with cpu_req & dma_req.
  - Adds output stall_cnt[31:0], counting cycles with cpu_stall==1.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by rst.
- When undefined: neither port nor any counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs high -> all grants, rvalids, mem_en and cpu_stall are 0; after release, the first cycle gives cpu_gnt=1.
- CPU read: write 32'hDEADBEEF to addr 5 via DMA alone, then a CPU read of addr 5 -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=32'hDEADBEEF one cycle later, dma_rvalid=0.
- Contention (STARVE_MAX=4, both reqs held) -> cpu_gnt 4 cycles with cpu_stall=0, then dma_gnt=1 with cpu_stall=1 on cycle 5, and the pattern repeats.
- Byte write: CPU write of 32'h000000AA with cpu_we=4'b0001 to addr 9 already holding 32'h11223344 -> a DMA read of addr 9 returns 32'h112233AA on dma_rdata.
- Alternating reads (CPU addr 1, then DMA addr 2 on the next cycle) -> cpu_rvalid then dma_rvalid on consecutive cycles, each with its own word.
- With ARB_PERF_CNT_EN: 10 contended cycles with STARVE_MAX=4 -> conflict_cnt=10 and stall_cnt=2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported data memory between the CPU execute-stage
//   load/store path and the UART loader DMA port. One grant per cycle, CPU
//   preferred, with a starvation counter that forces a DMA grant after
//   STARVE_MAX consecutive refused DMA cycles. Reads are tagged so the
//   returning mem_dout is steered to the port that issued the read.
//
//   Ports:
//     clk, rst                  clock, synchronous active-low reset
//     cpu_req/we/addr/wdata     CPU request (we==0 -> read)
//     cpu_gnt, cpu_stall        CPU accept / refuse (stall = req & ~gnt)
//     cpu_rvalid, cpu_rdata     CPU read return, one cycle after grant
//     dma_req/we/addr/wdata     DMA request (we==0 -> read)
//     dma_gnt                   DMA accept
//     dma_rvalid, dma_rdata     DMA read return, one cycle after grant
//     mem_en/we/addr/din        memory drive
//     mem_dout                  memory read data (1-cycle latency)
//
//   Optional: define ARB_PERF_CNT_EN to add conflict_cnt and stall_cnt,
//   saturating 32-bit counters of contended and stalled cycles.

module dmem_arbiter #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [3:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    input  logic          dma_req,
    input  logic [3:0]    dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
`ifdef ARB_PERF_CNT_EN
   ,output logic [31:0]   conflict_cnt,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } mreq_t;

    logic [SCW-1:0] starve_cnt;
    owner_t         rd_owner;
    logic [AW-1:0]  addr_q;
    logic [31:0]    din_q;
    logic           dma_forced;
    mreq_t          cpu_p, dma_p, sel_p;

    // Grants: rst gating keeps every grant and the stall low during reset.
    always_comb begin
        dma_forced = (starve_cnt == STARVE_TOP);
        cpu_gnt    = rst & cpu_req & (~dma_req | ~dma_forced);
        dma_gnt    = rst & dma_req & (~cpu_req | dma_forced);
        cpu_stall  = rst & cpu_req & ~cpu_gnt;
    end

    // Memory drive; address/data hold their last granted value when idle.
    always_comb begin
        cpu_p    = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        dma_p    = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
        sel_p    = cpu_gnt ? cpu_p : dma_p;
        mem_en   = cpu_gnt | dma_gnt;
        mem_we   = mem_en ? sel_p.we    : 4'b0000;
        mem_addr = mem_en ? sel_p.addr  : addr_q;
        mem_din  = mem_en ? sel_p.wdata : din_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            rd_owner   <= OWN_NONE;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            // Counts refused DMA cycles; the forced grant clears it, so the
            // saturation check only guards an out-of-sequence state.
            if (dma_req & ~dma_gnt) begin
                if (starve_cnt != STARVE_TOP)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            if (cpu_gnt && cpu_we == 4'b0000)
                rd_owner <= OWN_CPU;
            else if (dma_gnt && dma_we == 4'b0000)
                rd_owner <= OWN_DMA;
            else
                rd_owner <= OWN_NONE;

            addr_q <= mem_addr;
            din_q  <= mem_din;
        end
    end

    // Return path: gated by rst so a read whose data cycle lands in reset
    // is dropped.
    always_comb begin
        cpu_rvalid = rst & (rd_owner == OWN_CPU);
        dma_rvalid = rst & (rd_owner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? mem_dout : 32'h0;
        dma_rdata  = dma_rvalid ? mem_dout : 32'h0;
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (cpu_req && dma_req && conflict_cnt != 32'hFFFF_FFFF)
                conflict_cnt <= conflict_cnt + 32'd1;
            if (cpu_stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
